// File: rtl/idex_decode_queue.sv
// ID-stage decode queue: decodes MIPS32 words on push, buffers DEPTH decoded
// entries in order and presents them through a valid/ready handshake. A HI/LO
// busy counter holds MD/HILO heads after an MD-class dispatch.
module idex_decode_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int MD_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            ifid_valid,
  input  logic [31:0]     ifid_instr,
  input  logic [PC_W-1:0] ifid_pc,
  output logic            ifid_ready,
  output logic            idex_valid,
  input  logic            idex_ready,
  output logic [3:0]      idex_class,
  output logic [4:0]      idex_rs,
  output logic [4:0]      idex_rt,
  output logic [4:0]      idex_dest,
  output logic            idex_reg_w_en,
  output logic            idex_mem_r_en,
  output logic            idex_mem_w_en,
  output logic [31:0]     idex_imm,
  output logic [PC_W-1:0] idex_pc,
  output logic            idex_invalid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [3:0] MD_LAT_V = 4'(MD_LAT);

  localparam logic [3:0] C_NOP = 4'd0,  C_ALU_R = 4'd1, C_ALU_I = 4'd2,
                         C_SHIFT = 4'd3, C_BRANCH = 4'd4, C_JUMP = 4'd5,
                         C_LOAD = 4'd6, C_STORE = 4'd7, C_MD = 4'd8,
                         C_HILO = 4'd9, C_CP0 = 4'd10, C_SYSCALL = 4'd11,
                         C_ERET = 4'd12, C_TRAP = 4'd13, C_INV = 4'd15;

  typedef struct packed {
    logic [3:0]  cls;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        reg_w_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] imm;
  } dec_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    logic signed [15:0] sv;
    logic signed [31:0] s;
    sv = v;
    s  = sv;
    return s;
  endfunction

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sa;
    logic       wr_rd, wr_rt, wr_ra;
    op = ins[31:26]; fn = ins[5:0];
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sa = ins[10:6];
    d = '0;
    d.rs = rs;
    d.rt = rt;
    d.cls = C_INV;
    wr_rd = 1'b0; wr_rt = 1'b0; wr_ra = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h00, 6'h02, 6'h03: if (rs == '0) begin d.cls = C_SHIFT; wr_rd = 1'b1; end
          6'h04, 6'h06, 6'h07: if (sa == '0) begin d.cls = C_SHIFT; wr_rd = 1'b1; end
          6'h08: if (rt == '0 && rd == '0 && sa == '0) d.cls = C_JUMP;
          6'h09: if (rt == '0 && sa == '0) begin d.cls = C_JUMP; wr_rd = 1'b1; end
          6'h0A, 6'h0B, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: if (sa == '0) begin d.cls = C_ALU_R; wr_rd = 1'b1; end
          6'h0C, 6'h0D: d.cls = C_SYSCALL;
          6'h10, 6'h12: if (rs == '0 && rt == '0 && sa == '0) begin d.cls = C_HILO; wr_rd = 1'b1; end
          6'h11, 6'h13: if (rt == '0 && rd == '0 && sa == '0) d.cls = C_HILO;
          6'h18, 6'h19, 6'h1A, 6'h1B: if (rd == '0 && sa == '0) d.cls = C_MD;
          6'h30, 6'h31, 6'h32, 6'h33, 6'h34, 6'h36: d.cls = C_TRAP;
          default: ;
        endcase
      end
      6'h01: begin
        case (rt)
          5'h00, 5'h01: d.cls = C_BRANCH;
          5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0E: d.cls = C_TRAP;
          default: ;
        endcase
      end
      6'h02: d.cls = C_JUMP;
      6'h03: begin d.cls = C_JUMP; wr_ra = 1'b1; end
      6'h04, 6'h05: d.cls = C_BRANCH;
      6'h06, 6'h07: if (rt == '0) d.cls = C_BRANCH;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin d.cls = C_ALU_I; wr_rt = 1'b1; end
      6'h0F: if (rs == '0) begin d.cls = C_ALU_I; wr_rt = 1'b1; end
      6'h10: begin
        if (rs == 5'h00 && ins[10:3] == '0) begin d.cls = C_CP0; wr_rt = 1'b1; end
        else if (rs == 5'h04 && ins[10:3] == '0) d.cls = C_CP0;
        else if (rs == 5'h10 && ins[20:6] == '0 && fn == 6'h18) d.cls = C_ERET;
      end
      6'h1C: begin
        if (fn == 6'h02 && sa == '0) begin d.cls = C_MD; wr_rd = 1'b1; end
        else if ((fn == 6'h20 || fn == 6'h21) && sa == '0) begin d.cls = C_ALU_R; wr_rd = 1'b1; end
      end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25: begin d.cls = C_LOAD; wr_rt = 1'b1; d.mem_r_en = 1'b1; end
      6'h28, 6'h29, 6'h2B: begin d.cls = C_STORE; d.mem_w_en = 1'b1; end
      default: ;
    endcase
    case (op)
      6'h0C, 6'h0D, 6'h0E: d.imm = {16'h0000, ins[15:0]};
      6'h0F:               d.imm = {ins[15:0], 16'h0000};
      6'h02, 6'h03:        d.imm = {6'b0, ins[25:0]};
      default:             d.imm = sext16(ins[15:0]);
    endcase
    if (wr_rd) begin d.dest = rd; d.reg_w_en = 1'b1; end
    else if (wr_rt) begin d.dest = rt; d.reg_w_en = 1'b1; end
    else if (wr_ra) begin d.dest = 5'd31; d.reg_w_en = 1'b1; end
    if (ins == '0) begin
      d.cls = C_NOP;
      d.dest = '0;
      d.reg_w_en = 1'b0;
    end
    return d;
  endfunction

  dec_t            ent_mem [DEPTH];
  logic [PC_W-1:0] pc_mem  [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [3:0]       md_busy;
  dec_t             dec_p0;
  dec_t             head;
  logic             head_hold, push, pop;

  // Stage p0: decode of the offered word, written into the tail slot on push
  assign dec_p0     = decode(ifid_instr);
  assign ifid_ready = (count != CNT_W'(DEPTH));
  assign push       = ifid_valid && ifid_ready && !flush;

  // Head presentation: MD/HILO heads wait out the HI/LO busy window
  assign head       = ent_mem[rd_ptr];
  assign head_hold  = (md_busy != 4'd0) && (head.cls == C_MD || head.cls == C_HILO);
  assign idex_valid = (count != '0) && !head_hold;
  assign pop        = idex_valid && idex_ready && !flush;

  // Payload is zeroed whenever nothing is presented
  always_comb begin
    idex_class    = '0;
    idex_rs       = '0;
    idex_rt       = '0;
    idex_dest     = '0;
    idex_reg_w_en = 1'b0;
    idex_mem_r_en = 1'b0;
    idex_mem_w_en = 1'b0;
    idex_imm      = '0;
    idex_pc       = '0;
    idex_invalid  = 1'b0;
    if (idex_valid) begin
      idex_class    = head.cls;
      idex_rs       = head.rs;
      idex_rt       = head.rt;
      idex_dest     = head.dest;
      idex_reg_w_en = head.reg_w_en;
      idex_mem_r_en = head.mem_r_en;
      idex_mem_w_en = head.mem_w_en;
      idex_imm      = head.imm;
      idex_pc       = pc_mem[rd_ptr];
      idex_invalid  = (head.cls == C_INV);
    end
  end

  // Entry storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      ent_mem[wr_ptr] <= dec_p0;
      pc_mem[wr_ptr]  <= ifid_pc;
    end
  end

  // Queue control and HI/LO busy counter; flush clears queue but not md_busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      md_busy <= 4'd0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
      if (pop && head.cls == C_MD) md_busy <= MD_LAT_V;
      else if (md_busy != 4'd0)    md_busy <= md_busy - 4'd1;
    end
  end

endmodule
